// File: rtl/sevenseg_scan_decoder.sv
// Receive side of a multiplexed 7-segment display bus: synchronise, glitch-filter and decode.
// Optional macro SEVENSEG_SCAN_BLANK_EN accepts the all-off code as a legal blank digit.
module sevenseg_scan_decoder #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned IDXW          = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_seg,
    input  logic [DIGITS-1:0]     i_an,
    input  logic                  i_clr,
    output logic [4*DIGITS-1:0]   o_hex,
    output logic [DIGITS-1:0]     o_valid,
    output logic [DIGITS-1:0]     o_err,
`ifdef SEVENSEG_SCAN_BLANK_EN
    output logic [DIGITS-1:0]     o_blank,
`endif
    output logic                  o_anerr,
    output logic                  o_upd,
    output logic [IDXW-1:0]       o_upd_idx,
    output logic                  o_frame
);

    localparam int unsigned CNTW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(STABLE_CYCLES);
    localparam logic [CNTW-1:0] ACCEPT_AT = CNTW'(STABLE_CYCLES - 1);

    logic [7:0]          r_seg_meta, r_seg_sync;
    logic [DIGITS-1:0]   r_an_meta, r_an_sync;
    logic [CNTW-1:0]     r_cnt;
    logic [4*DIGITS-1:0] r_hex;
    logic [DIGITS-1:0]   r_valid, r_err, r_seen;
    logic                r_anerr, r_upd, r_frame;
    logic [IDXW-1:0]     r_upd_idx;
`ifdef SEVENSEG_SCAN_BLANK_EN
    logic [DIGITS-1:0]   r_blank;
    logic [DIGITS-1:0]   w_blank_nxt;
    logic                w_blank_code;
`endif

    logic                w_same;
    logic                w_accept;
    logic [CNTW-1:0]     w_cnt_nxt;
    logic [DIGITS-1:0]   w_an_low;
    logic                w_an_any, w_an_multi;
    logic [IDXW-1:0]     w_an_idx;
    logic [4:0]          w_code;
    logic                w_code_ok;
    logic [3:0]          w_code_nib;
    logic [4*DIGITS-1:0] w_hex_nxt;
    logic [DIGITS-1:0]   w_valid_nxt, w_err_nxt, w_seen_nxt;
    logic                w_anerr_nxt, w_upd_nxt, w_frame_nxt;
    logic [IDXW-1:0]     w_idx_nxt;

    function automatic logic [4:0] decode_seg(input logic [7:0] seg);
        logic [4:0] res;
        case (seg)
            8'b0100_0000: res = {1'b1, 4'h0};
            8'b0111_1001: res = {1'b1, 4'h1};
            8'b0010_0100: res = {1'b1, 4'h2};
            8'b0011_0000: res = {1'b1, 4'h3};
            8'b0001_1001: res = {1'b1, 4'h4};
            8'b0001_0010: res = {1'b1, 4'h5};
            8'b0000_0010: res = {1'b1, 4'h6};
            8'b0111_1000: res = {1'b1, 4'h7};
            8'b0000_0000: res = {1'b1, 4'h8};
            8'b0001_0000: res = {1'b1, 4'h9};
            8'b1000_1000: res = {1'b1, 4'hA};
            8'b1000_0000: res = {1'b1, 4'hB};
            8'b1100_0110: res = {1'b1, 4'hC};
            8'b1100_0000: res = {1'b1, 4'hD};
            8'b1000_0110: res = {1'b1, 4'hE};
            8'b1000_1110: res = {1'b1, 4'hF};
            default:      res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // Idle synchronizer state is all-ones: blank segments, no anode driven.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_seg_meta <= '1;
            r_seg_sync <= '1;
            r_an_meta  <= '1;
            r_an_sync  <= '1;
        end else begin
            r_seg_meta <= i_seg;
            r_seg_sync <= r_seg_meta;
            r_an_meta  <= i_an;
            r_an_sync  <= r_an_meta;
        end
    end

    // Comparing the first stage against S detects a change in S one cycle early, so the
    // counter and the accepted sample line up with the S-vs-previous-S definition.
    assign w_same   = (r_seg_meta == r_seg_sync) && (r_an_meta == r_an_sync);
    assign w_accept = w_same && (r_cnt == ACCEPT_AT);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!w_same) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNTW'(1);
        end
    end

    assign w_an_low   = ~r_an_sync;
    assign w_an_any   = |w_an_low;
    assign w_an_multi = (w_an_low & (w_an_low - DIGITS'(1))) != '0;

    always_comb begin
        w_an_idx = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (w_an_low[i]) begin
                w_an_idx = IDXW'(i);
            end
        end
    end

    assign w_code     = decode_seg(r_seg_sync);
    assign w_code_ok  = w_code[4];
    assign w_code_nib = w_code[3:0];
`ifdef SEVENSEG_SCAN_BLANK_EN
    assign w_blank_code = (r_seg_sync == 8'hFF);
`endif

    // Clear first so that a simultaneous accept still lands on its own digit.
    always_comb begin
        w_hex_nxt   = r_hex;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        w_seen_nxt  = r_seen;
        w_anerr_nxt = r_anerr;
        w_upd_nxt   = 1'b0;
        w_frame_nxt = 1'b0;
        w_idx_nxt   = r_upd_idx;
`ifdef SEVENSEG_SCAN_BLANK_EN
        w_blank_nxt = r_blank;
`endif
        if (i_clr) begin
            w_valid_nxt = '0;
            w_err_nxt   = '0;
            w_seen_nxt  = '0;
            w_anerr_nxt = 1'b0;
`ifdef SEVENSEG_SCAN_BLANK_EN
            w_blank_nxt = '0;
`endif
        end
        if (w_accept && w_an_any) begin
            if (w_an_multi) begin
                w_anerr_nxt = 1'b1;
            end else begin
                w_upd_nxt  = 1'b1;
                w_idx_nxt  = w_an_idx;
                w_seen_nxt = w_seen_nxt | w_an_low;
                if (&w_seen_nxt) begin
                    w_frame_nxt = 1'b1;
                    w_seen_nxt  = '0;
                end
                if (w_code_ok) begin
                    for (int i = 0; i < int'(DIGITS); i++) begin
                        if (w_an_low[i]) begin
                            w_hex_nxt[4*i +: 4] = w_code_nib;
                        end
                    end
                    w_valid_nxt = w_valid_nxt | w_an_low;
`ifdef SEVENSEG_SCAN_BLANK_EN
                    w_blank_nxt = w_blank_nxt & ~w_an_low;
                end else if (w_blank_code) begin
                    for (int i = 0; i < int'(DIGITS); i++) begin
                        if (w_an_low[i]) begin
                            w_hex_nxt[4*i +: 4] = 4'h0;
                        end
                    end
                    w_valid_nxt = w_valid_nxt & ~w_an_low;
                    w_blank_nxt = w_blank_nxt | w_an_low;
`endif
                end else begin
                    w_err_nxt = w_err_nxt | w_an_low;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_hex     <= '0;
            r_valid   <= '0;
            r_err     <= '0;
            r_seen    <= '0;
            r_anerr   <= 1'b0;
            r_upd     <= 1'b0;
            r_frame   <= 1'b0;
            r_upd_idx <= '0;
`ifdef SEVENSEG_SCAN_BLANK_EN
            r_blank   <= '0;
`endif
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_hex     <= w_hex_nxt;
            r_valid   <= w_valid_nxt;
            r_err     <= w_err_nxt;
            r_seen    <= w_seen_nxt;
            r_anerr   <= w_anerr_nxt;
            r_upd     <= w_upd_nxt;
            r_frame   <= w_frame_nxt;
            r_upd_idx <= w_idx_nxt;
`ifdef SEVENSEG_SCAN_BLANK_EN
            r_blank   <= w_blank_nxt;
`endif
        end
    end

    assign o_hex     = r_hex;
    assign o_valid   = r_valid;
    assign o_err     = r_err;
    assign o_anerr   = r_anerr;
    assign o_upd     = r_upd;
    assign o_upd_idx = r_upd_idx;
    assign o_frame   = r_frame;
`ifdef SEVENSEG_SCAN_BLANK_EN
    assign o_blank   = r_blank;
`endif

endmodule
